// File: rtl/bram_req_arbiter_if.sv
// Request/response bus between N_REQ requesters and bram_req_arbiter.
//
// Signals (slices are packed per requester, requester i in slice i):
//   req_valid  N_REQ               request present
//   req_ready  N_REQ               request accepted this cycle (grant)
//   req_addr   N_REQ*ADDR_WIDTH    word address
//   req_wstrb  N_REQ*DATA_WIDTH/8  byte enables; all-zero means read
//   req_wdata  N_REQ*DATA_WIDTH    write data
//   rsp_valid  N_REQ               read data valid for requester i (one-hot or zero)
//   rsp_data   DATA_WIDTH          read data, shared by all requesters
//
// Modports: master = requester side, slave = arbiter side.
interface bram_req_arbiter_if #(
    parameter int N_REQ      = 2,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
);
    logic [N_REQ-1:0]              req_valid;
    logic [N_REQ-1:0]              req_ready;
    logic [N_REQ*ADDR_WIDTH-1:0]   req_addr;
    logic [N_REQ*DATA_WIDTH/8-1:0] req_wstrb;
    logic [N_REQ*DATA_WIDTH-1:0]   req_wdata;
    logic [N_REQ-1:0]              rsp_valid;
    logic [DATA_WIDTH-1:0]         rsp_data;

    modport master (
        output req_valid, req_addr, req_wstrb, req_wdata,
        input  req_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  req_valid, req_addr, req_wstrb, req_wdata,
        output req_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/bram_req_arbiter.sv
// Shares one dual-port byte-write BRAM (1 write port, 1 read port, 1-cycle
// read latency) among N_REQ requesters. Each cycle at most one write and one
// read are granted, each chosen by its own round-robin arbiter. Read data
// comes back one cycle after acceptance, tagged with the issuing requester.
//
// Ports:
//   clk         clock
//   rst         synchronous reset, active-high
//   req_if      slave side of bram_req_arbiter_if (requests, grants, responses)
//   bram_waddr  BRAM write address
//   bram_din    BRAM write data
//   bram_we     BRAM byte write enables
//   bram_raddr  BRAM read address
//   bram_dout   BRAM read data (valid the cycle after bram_raddr was presented)
module bram_req_arbiter #(
    parameter int N_REQ      = 2,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    bram_req_arbiter_if.slave       req_if,
    output logic [ADDR_WIDTH-1:0]   bram_waddr,
    output logic [DATA_WIDTH-1:0]   bram_din,
    output logic [DATA_WIDTH/8-1:0] bram_we,
    output logic [ADDR_WIDTH-1:0]   bram_raddr,
    input  logic [DATA_WIDTH-1:0]   bram_dout
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int PTR_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef logic [PTR_W-1:0] ptr_t;

    // Per-requester views of the packed request buses
    logic [ADDR_WIDTH-1:0] slot_addr  [N_REQ];
    logic [STRB_W-1:0]     slot_strb  [N_REQ];
    logic [DATA_WIDTH-1:0] slot_wdata [N_REQ];
    logic [N_REQ-1:0]      wr_cand;
    logic [N_REQ-1:0]      rd_cand;

    // Arbitration state and read pipeline
    ptr_t                  wptr;
    ptr_t                  rptr;
    logic                  rd_vld;
    ptr_t                  rd_id;
    logic [ADDR_WIDTH-1:0] raddr_q;

    // Grant decode
    logic [PTR_W:0]        w_pick;
    logic [PTR_W:0]        r_pick;
    logic                  w_gnt;
    logic                  r_gnt;
    ptr_t                  w_idx;
    ptr_t                  r_idx;

    // Round-robin search starting at 'start', wrapping modulo N_REQ.
    // Returns {found, index}. The loop walks offsets from farthest to nearest
    // so the candidate closest to the pointer overwrites any earlier hit.
    function automatic logic [PTR_W:0] rr_pick(input logic [N_REQ-1:0] cand,
                                               input ptr_t start);
        logic [PTR_W:0] result;
        int             idx;
        result = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = int'(start) + k;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            if (cand[ptr_t'(idx)]) begin
                result = {1'b1, ptr_t'(idx)};
            end
        end
        return result;
    endfunction

    function automatic ptr_t next_ptr(input ptr_t g);
        return (g == ptr_t'(N_REQ - 1)) ? '0 : g + ptr_t'(1);
    endfunction

    for (genvar i = 0; i < N_REQ; i++) begin : g_slot
        assign slot_addr[i]  = req_if.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        assign slot_strb[i]  = req_if.req_wstrb[i*STRB_W +: STRB_W];
        assign slot_wdata[i] = req_if.req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
        assign wr_cand[i]    = req_if.req_valid[i] && (slot_strb[i] != '0);
        assign rd_cand[i]    = req_if.req_valid[i] && (slot_strb[i] == '0);
    end

    // Grants are suppressed while rst is high so nothing transfers in reset.
    always_comb begin
        w_pick = rr_pick(wr_cand, wptr);
        r_pick = rr_pick(rd_cand, rptr);
        w_gnt  = w_pick[PTR_W] && !rst;
        r_gnt  = r_pick[PTR_W] && !rst;
        w_idx  = w_pick[PTR_W-1:0];
        r_idx  = r_pick[PTR_W-1:0];
    end

    always_comb begin
        req_if.req_ready = '0;
        if (w_gnt) begin
            req_if.req_ready[w_idx] = 1'b1;
        end
        if (r_gnt) begin
            req_if.req_ready[r_idx] = 1'b1;
        end
    end

    // Write port is driven straight from the granted slot; idle means all zero.
    always_comb begin
        bram_we    = '0;
        bram_waddr = '0;
        bram_din   = '0;
        if (w_gnt) begin
            bram_we    = slot_strb[w_idx];
            bram_waddr = slot_addr[w_idx];
            bram_din   = slot_wdata[w_idx];
        end
    end

    // With no read grant the read address parks on the last granted address.
    assign bram_raddr = r_gnt ? slot_addr[r_idx] : raddr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr    <= '0;
            rptr    <= '0;
            rd_vld  <= 1'b0;
            rd_id   <= '0;
            raddr_q <= '0;
        end else begin
            if (w_gnt) begin
                wptr <= next_ptr(w_idx);
            end
            if (r_gnt) begin
                rptr    <= next_ptr(r_idx);
                rd_id   <= r_idx;
                raddr_q <= slot_addr[r_idx];
            end
            rd_vld <= r_gnt;
        end
    end

    // Gating with rst drops the response of a read accepted just before reset.
    always_comb begin
        req_if.rsp_valid = '0;
        if (rd_vld && !rst) begin
            req_if.rsp_valid[rd_id] = 1'b1;
        end
    end

    assign req_if.rsp_data = bram_dout;

endmodule
